// File: rtl/dmem_controller.sv
// Load/store sequencer between execute and the shared data-memory bus.
// Handles one request at a time: aligned word writes, read-modify-write for SB/SH, and extended loads.
module dmem_controller #(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_wen,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        stall,
  output logic        resp_valid,
  output logic        resp_wen,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [31:0] dmem_addr,
  output logic        dmem_wen,
  inout  wire  [31:0] dmem_data
);

  localparam int CW = (READ_LAT < 2) ? 1 : $clog2(READ_LAT + 1);
  localparam logic [CW-1:0] LAT_INIT = CW'(READ_LAT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LDONE, S_RMW_READ, S_RMW_WRITE, S_WRITE, S_ERR
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     lane_q, lane_d;
  logic [2:0]     f3_q, f3_d;
  logic [15:0]    wdata_q, wdata_d;
  logic [4:0]     rd_q, rd_d;
  logic           resp_valid_q, resp_valid_d;
  logic           resp_wen_q, resp_wen_d;
  logic           resp_err_q, resp_err_d;
  logic [4:0]     resp_rd_q, resp_rd_d;
  logic [31:0]    resp_data_q, resp_data_d;
  logic [31:0]    dmem_addr_q, dmem_addr_d;
  logic           dmem_wen_q, dmem_wen_d;
  logic [31:0]    dmem_wdata_q, dmem_wdata_d;

  function automatic logic req_illegal(input logic wen, input logic [2:0] f3, input logic [1:0] a);
    logic bad_f3, mis;
    bad_f3 = wen ? (f3[2] || f3[1:0] == 2'b11)
                 : ((f3[1] && f3[0]) || (f3[2] && f3[1]));
    mis    = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
    return bad_f3 || mis;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [2:0] f3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   r = f3[2] ? {24'd0, b} : 32'(b);
      2'b01:   r = f3[2] ? {16'd0, h} : 32'(h);
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [1:0] lane,
                                              input logic half, input logic [15:0] d);
    logic [31:0] r;
    r = w;
    if (half) begin
      if (lane[1]) r[31:16] = d;
      else         r[15:0]  = d;
    end else begin
      case (lane)
        2'd0:    r[7:0]   = d[7:0];
        2'd1:    r[15:8]  = d[7:0];
        2'd2:    r[23:16] = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
    end
    return r;
  endfunction

  assign stall      = (state_q == S_IDLE && req_valid) || state_q == S_READ || state_q == S_RMW_READ;
  assign resp_valid = resp_valid_q;
  assign resp_wen   = resp_wen_q;
  assign resp_err   = resp_err_q;
  assign resp_rd    = resp_rd_q;
  assign resp_data  = resp_data_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wen   = dmem_wen_q;
  assign dmem_data  = dmem_wen_q ? dmem_wdata_q : 32'bz;

  // Outputs are computed one cycle ahead so every bus/response signal comes straight from a flop.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lane_d       = lane_q;
    f3_d         = f3_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    dmem_wdata_d = dmem_wdata_q;
    resp_valid_d = 1'b0;
    resp_wen_d   = 1'b0;
    resp_err_d   = 1'b0;
    resp_rd_d    = 5'd0;
    resp_data_d  = 32'd0;
    dmem_addr_d  = 32'd0;
    dmem_wen_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          lane_d  = req_addr[1:0];
          f3_d    = req_funct3;
          wdata_d = req_wdata[15:0];
          rd_d    = req_rd;
          cnt_d   = LAT_INIT;
          if (req_illegal(req_wen, req_funct3, req_addr[1:0])) begin
            state_d      = S_ERR;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (req_wen && req_funct3[1]) begin
            state_d      = S_WRITE;
            dmem_addr_d  = {req_addr[31:2], 2'b00};
            dmem_wen_d   = 1'b1;
            dmem_wdata_d = req_wdata;
            resp_valid_d = 1'b1;
          end else begin
            state_d     = req_wen ? S_RMW_READ : S_READ;
            dmem_addr_d = {req_addr[31:2], 2'b00};
          end
        end
      end
      S_READ, S_RMW_READ: begin
        dmem_addr_d = dmem_addr_q;
        cnt_d       = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          resp_valid_d = 1'b1;
          if (state_q == S_READ) begin
            state_d     = S_LDONE;
            resp_wen_d  = (rd_q != 5'd0);
            resp_rd_d   = rd_q;
            resp_data_d = load_ext(dmem_data, lane_q, f3_q);
          end else begin
            state_d      = S_RMW_WRITE;
            dmem_wen_d   = 1'b1;
            dmem_wdata_d = store_merge(dmem_data, lane_q, f3_q[0], wdata_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_wen_q   <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rd_q    <= 5'd0;
      resp_data_q  <= 32'd0;
      dmem_addr_q  <= 32'd0;
      dmem_wen_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_wen_q   <= resp_wen_d;
      resp_err_q   <= resp_err_d;
      resp_rd_q    <= resp_rd_d;
      resp_data_q  <= resp_data_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wen_q   <= dmem_wen_d;
    end
  end

  // Request fields and write word are only consumed after being loaded, so they carry no reset.
  always_ff @(posedge clk) begin
    lane_q       <= lane_d;
    f3_q         <= f3_d;
    wdata_q      <= wdata_d;
    rd_q         <= rd_d;
    dmem_wdata_q <= dmem_wdata_d;
  end

endmodule
